// File: rtl/dcache_rmw_ctrl.sv
// Sub-word load/store sequencer for a single-port, word-wide data SRAM with 1-cycle read latency.
// Stores merge into the read word (read-modify-write); loads shift and extend the addressed lane.
module dcache_rmw_ctrl #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MG,
        S_WR,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [31:0]       data_q, data_d;
    logic              err_q, err_d;

    logic              misaligned;
    logic [4:0]        shamt;
    logic [31:0]       shifted;
    logic [31:0]       lane_mask;
    logic [31:0]       lane_data;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        data_d     = data_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        ram_addr   = addr_q[ADDR_W-1:2];

        misaligned = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        shamt      = {addr_q[1:0], 3'b000};
        shifted    = ram_rdata >> shamt;
        lane_mask  = (size_q == 2'b00) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
        lane_data  = (size_q == 2'b00) ? ({24'h0, data_q[7:0]} << shamt)
                                       : ({16'h0, data_q[15:0]} << shamt);

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    write_d  = req_write;
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    // data_q carries store data until MG replaces it with the merged/extended word
                    data_d   = req_wdata;
                    err_d    = misaligned;
                    if (misaligned)
                        state_d = S_RESP;
                    else if (req_write && req_size == 2'b10)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                ram_en  = 1'b1;
                state_d = S_MG;
            end
            S_MG: begin
                if (write_q) begin
                    data_d  = (ram_rdata & ~lane_mask) | lane_data;
                    state_d = S_WR;
                end else begin
                    unique case (size_q)
                        2'b00:   data_d = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                        2'b01:   data_d = {{16{signed_q & shifted[15]}}, shifted[15:0]};
                        default: data_d = shifted;
                    endcase
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                // Gated by rst_n so a reset landing on the write cycle abandons the write
                ram_en    = rst_n;
                ram_we    = rst_n;
                ram_wdata = data_q;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (write_q || err_q) ? '0 : data_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            signed_q <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_dcache_rmw_ctrl.sv
// Scoreboard bench for dcache_rmw_ctrl: directed requests push expected responses and SRAM writes,
// a negedge monitor pops and compares them, including latency from the accept cycle.
module tb_dcache_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    dcache_rmw_ctrl #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    typedef struct {
        logic [9:0]  idx;
        logic [31:0] data;
        int          lat;
    } wr_t;

    rsp_t        rq[$];
    wr_t         wq[$];
    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_resp_cyc = 0;
    int          ram_en_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
    end

    // Monitor: everything the DUT presents is checked against the queues
    always @(negedge clk) begin
        if (rst_n && req_valid && req_ready) acc_cyc = cyc;
        if (ram_en) ram_en_cnt++;
        if (ram_en && ram_we) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: idx=%0d data=%h, required no write", ram_addr, ram_wdata);
            end else begin
                wr_t w;
                w = wq.pop_front();
                if (ram_addr !== w.idx || ram_wdata !== w.data || (cyc - acc_cyc) != w.lat) begin
                    errors++;
                    $display("FAIL ram_write: idx=%0d data=%h lat=%0d, required idx=%0d data=%h lat=%0d",
                             ram_addr, ram_wdata, cyc - acc_cyc, w.idx, w.data, w.lat);
                end
            end
        end
        if (resp_valid) begin
            checks++;
            last_resp_cyc = cyc;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: rdata=%h err=%b, required no response", resp_rdata, resp_err);
            end else begin
                rsp_t r;
                r = rq.pop_front();
                if (resp_rdata !== r.rdata || resp_err !== r.err || (cyc - acc_cyc) != r.lat) begin
                    errors++;
                    $display("FAIL resp: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                             resp_rdata, resp_err, cyc - acc_cyc, r.rdata, r.err, r.lat);
                end
            end
        end
    end

    task automatic exp_rsp(input logic [31:0] d, input logic e, input int lat);
        rsp_t r;
        r.rdata = d; r.err = e; r.lat = lat;
        rq.push_back(r);
    endtask

    task automatic exp_wr(input logic [9:0] idx, input logic [31:0] d, input int lat);
        wr_t w;
        w.idx = idx; w.data = d; w.lat = lat;
        wq.push_back(w);
    endtask

    task automatic drive(input logic w, input logic [11:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        req_write = w; req_addr = a; req_size = sz; req_signed = sg; req_wdata = wd;
    endtask

    // Returns #1 after the accepting edge, with inputs scrambled to prove they were latched
    task automatic issue(input logic w, input logic [11:0] a, input logic [1:0] sz,
                         input logic sg, input logic [31:0] wd);
        int n;
        @(negedge clk);
        drive(w, a, sz, sg, wd);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drive(~w, ~a, ~sz, ~sg, ~wd);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL %s_timeout: pending rsp=%0d wr=%0d, required 0 0", name, rq.size(), wq.size());
        end
        @(negedge clk);
    endtask

    initial begin
        int en_before;
        int acc2;
        int n;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        ram_rdata = '0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        drive(1'b0, 12'h0, 2'b00, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_err !== 1'b0 ||
            ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b rv=%b rd=%h re=%b en=%b we=%b ad=%h wd=%h, required 1 0 0 0 0 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_we, ram_addr, ram_wdata);
        end

        // Word store: write at T+1, response at T+2
        exp_wr(10'd4, 32'hDEADBEEF, 1);
        exp_rsp(32'h0, 1'b0, 2);
        issue(1'b1, 12'h010, 2'b10, 1'b0, 32'hDEADBEEF);
        wait_done("word_store");

        // Byte store merge
        mem[4] = 32'h11223344;
        exp_wr(10'd4, 32'h11AB3344, 3);
        exp_rsp(32'h0, 1'b0, 4);
        issue(1'b1, 12'h012, 2'b00, 1'b0, 32'h000000AB);
        wait_done("byte_store");

        // Loads with shift and extension
        mem[4] = 32'h80FF7F01;
        exp_rsp(32'hFFFFFF80, 1'b0, 3); issue(1'b0, 12'h013, 2'b00, 1'b1, 32'h0); wait_done("lb_signed");
        exp_rsp(32'h00000080, 1'b0, 3); issue(1'b0, 12'h013, 2'b00, 1'b0, 32'h0); wait_done("lb_unsigned");
        exp_rsp(32'h00007F01, 1'b0, 3); issue(1'b0, 12'h010, 2'b01, 1'b1, 32'h0); wait_done("lh_signed_lo");
        exp_rsp(32'hFFFF80FF, 1'b0, 3); issue(1'b0, 12'h012, 2'b01, 1'b1, 32'h0); wait_done("lh_signed_hi");
        exp_rsp(32'h0000007F, 1'b0, 3); issue(1'b0, 12'h011, 2'b00, 1'b0, 32'h0); wait_done("lb_off1");
        exp_rsp(32'h80FF7F01, 1'b0, 3); issue(1'b0, 12'h010, 2'b10, 1'b1, 32'h0); wait_done("lw");

        // Misaligned / illegal: error at T+1, SRAM untouched
        en_before = ram_en_cnt;
        exp_rsp(32'h0, 1'b1, 1); issue(1'b1, 12'h011, 2'b01, 1'b0, 32'h1234); wait_done("err_half");
        exp_rsp(32'h0, 1'b1, 1); issue(1'b0, 12'h012, 2'b10, 1'b0, 32'h0);    wait_done("err_word");
        exp_rsp(32'h0, 1'b1, 1); issue(1'b0, 12'h010, 2'b11, 1'b1, 32'h0);    wait_done("err_size");
        checks++;
        if (ram_en_cnt != en_before) begin
            errors++;
            $display("FAIL err_no_ram: ram_en cycles=%0d, required 0", ram_en_cnt - en_before);
        end

        // Half store at offset 2
        mem[4] = 32'h11223344;
        exp_wr(10'd4, 32'hCAFE3344, 3);
        exp_rsp(32'h0, 1'b0, 4);
        issue(1'b1, 12'h012, 2'b01, 1'b0, 32'h0000CAFE);
        wait_done("half_store");

        // Reset during WR of a second sub-word store: no write, no response
        issue(1'b1, 12'h010, 2'b00, 1'b0, 32'h00000055);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ram_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: rdy=%b rv=%b en=%b, required 1 0 0", req_ready, resp_valid, ram_en);
        end
        repeat (5) @(negedge clk);
        exp_rsp(32'hCAFE3344, 1'b0, 3);
        issue(1'b0, 12'h010, 2'b10, 1'b0, 32'h0);
        wait_done("after_abort");

        // Back-to-back with req_valid held: second accept exactly one cycle after first response
        mem[5] = 32'hA1B2C3D4;
        exp_rsp(32'h000000C3, 1'b0, 3);
        exp_rsp(32'hFFFFA1B2, 1'b0, 3);
        @(negedge clk);
        drive(1'b0, 12'h015, 2'b00, 1'b0, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        #1 drive(1'b0, 12'h016, 2'b01, 1'b1, 32'h0);
        n = 0;
        acc2 = 0;
        @(negedge clk);
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        acc2 = cyc;
        @(posedge clk);
        #1 req_valid = 1'b0;
        checks++;
        if (n >= 30 || acc2 != last_resp_cyc + 1) begin
            errors++;
            $display("FAIL b2b_spacing: second accept cycle=%0d, required %0d", acc2, last_resp_cyc + 1);
        end
        wait_done("b2b");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time exceeded");
        $fatal(1, "timeout");
    end

endmodule
